uart_rx_assembler: RTL

- Serial receive front end. Converts an asynchronous, LSB-first, 8N1 serial line into parallel bytes.
- Its byte_done output drives shift_enable of the downstream 8-bit parallel holding register; rx_data drives that register's data_in.
- Handles start-bit detection, mid-bit sampling, bit counting and stop-bit checking.
- Runs entirely in the clk domain.

---
 rtl/uart_rx_assembler.sv | 102 ++++++++++
 1 files changed

// File: rtl/uart_rx_assembler.sv
// uart_rx_assembler: 8N1 LSB-first serial receiver producing framed bytes and a one-cycle byte_done strobe.
module uart_rx_assembler #(
    parameter int CLKS_PER_BIT = 10,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       byte_done,
    output logic       framing_error,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_param
            $error("uart_rx_assembler: CLKS_PER_BIT must be 4 or more");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state, state_nx;
    logic            s1, rx_s;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [7:0]      shreg, shreg_nx, rx_data_nx;
    logic            byte_done_nx, fe_nx;
    logic            half_tick, last_tick;

    assign half_tick = cnt == CW'(HALF_BIT - 1);
    assign last_tick = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1            <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            byte_done     <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            s1            <= serial_in;
            rx_s          <= s1;
            state         <= state_nx;
            cnt           <= cnt_nx;
            bit_idx       <= bit_idx_nx;
            shreg         <= shreg_nx;
            rx_data       <= rx_data_nx;
            byte_done     <= byte_done_nx;
            framing_error <= fe_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + 1'b1;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        rx_data_nx   = rx_data;
        byte_done_nx = 1'b0;
        fe_nx        = framing_error;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = rx_s ? IDLE : START;
            end
            START: if (half_tick) begin
                cnt_nx     = '0;
                bit_idx_nx = '0;
                state_nx   = rx_s ? IDLE : DATA;
            end
            // right shift so the first (LSB) bit lands in bit 0 after eight samples
            DATA: if (last_tick) begin
                cnt_nx     = '0;
                shreg_nx   = {rx_s, shreg[7:1]};
                bit_idx_nx = bit_idx + 1'b1;
                state_nx   = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (last_tick) begin
                cnt_nx       = '0;
                fe_nx        = !rx_s;
                rx_data_nx   = rx_s ? shreg : rx_data;
                byte_done_nx = rx_s;
                state_nx     = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_nx   = '0;
                state_nx = rx_s ? IDLE : WAIT_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end
endmodule
